// File: rtl/fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch aligner.
package fetch_pkg;
  localparam int BUF_BYTES    = 12;
  localparam int MAX_OPE_LEN  = 6;
  localparam int FETCH_THRESH = 8;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fstate_t;
endpackage

// File: rtl/byte_queue.sv
// 12-byte shift/append buffer: pop from the head, then push behind the survivors.
module byte_queue
  import fetch_pkg::*;
(
  input  logic             clk2,
  input  logic             reset,
  input  logic             flush,
  input  logic [3:0]       pop,
  input  logic [31:0]      push_data,
  input  logic [2:0]       push_cnt,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      head
);
  logic [BUF_BYTES-1:0][7:0] q, q_nx;
  logic [CNT_W-1:0]          base, idx, cnt_nx;

  always_comb begin
    q_nx = q >> {pop, 3'b000};
    base = count - pop;
    idx  = '0;
    for (int j = 0; j < 4; j++) begin
      idx = base + CNT_W'(j);
      if (j < int'(push_cnt) && int'(idx) < BUF_BYTES)
        q_nx[idx] = push_data[8*j +: 8];
    end
    cnt_nx = flush ? '0 : base + CNT_W'(push_cnt);
  end

  always_ff @(posedge clk2 or posedge reset)
    if (reset) begin
      q     <= '0;
      count <= '0;
    end else begin
      q     <= q_nx;
      count <= cnt_nx;
    end

  assign head = {q[0], q[1], q[2], q[3]};
endmodule

// File: rtl/fetch_align.sv
// Fetch aligner: word-fetches from instruction memory into a byte buffer and
// presents the bytes at eip big-end-first to decode.
module fetch_align
  import fetch_pkg::*;
(
  input  logic        clk2,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic [3:0]  advance,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] ope,
  output logic        ope_valid,
  output logic [31:0] eip,
  output logic        adv_err
);
  fstate_t          state;
  logic [31:0]      fetch_addr;
  logic [1:0]       skip;
  logic [CNT_W-1:0] count, proj, proj_fill;
  logic             adv_ok, adv_bad, take;
  logic [3:0]       pop;
  logic [2:0]       push_cnt;
  logic [31:0]      push_data;

  assign ope_valid = count >= CNT_W'(MAX_OPE_LEN);
  assign adv_ok    = ope_valid && advance <= 4'(MAX_OPE_LEN);
  assign adv_bad   = advance > 4'(MAX_OPE_LEN) || (advance != '0 && !ope_valid);
  assign pop       = (adv_ok && !jump) ? advance : '0;
  // a jump discards any data arriving in the same cycle
  assign take      = state == WAIT && mem_ack && !jump;
  assign push_cnt  = take ? 3'd4 - {1'b0, skip} : '0;
  assign push_data = mem_rdata >> {skip, 3'b000};
  assign proj      = count - pop;
  assign proj_fill = proj + CNT_W'(push_cnt);

  byte_queue u_q (
    .clk2      (clk2),
    .reset     (reset),
    .flush     (jump),
    .pop       (pop),
    .push_data (push_data),
    .push_cnt  (push_cnt),
    .count     (count),
    .head      (ope)
  );

  always_ff @(posedge clk2 or posedge reset)
    if (reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fetch_addr <= '0;
      skip       <= '0;
      eip        <= '0;
      adv_err    <= 1'b0;
    end else begin
      if (adv_bad) adv_err <= 1'b1;
      if (jump) begin
        eip        <= jump_target;
        fetch_addr <= {jump_target[31:2], 2'b00};
        skip       <= jump_target[1:0];
      end else begin
        eip <= eip + 32'(pop);
      end
      case (state)
        IDLE:
          if (!jump && proj <= CNT_W'(FETCH_THRESH)) begin
            state    <= WAIT;
            mem_req  <= 1'b1;
            mem_addr <= fetch_addr;
          end
        WAIT:
          if (mem_ack) begin
            if (jump) begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end else begin
              skip       <= '0;
              fetch_addr <= fetch_addr + 32'd4;
              // chain straight into the next word while room remains
              if (proj_fill <= CNT_W'(FETCH_THRESH))
                mem_addr <= fetch_addr + 32'd4;
              else begin
                state   <= IDLE;
                mem_req <= 1'b0;
              end
            end
          end else if (jump) begin
            state <= DROP;
          end
        DROP:
          if (mem_ack) begin
            if (jump) begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end else begin
              state    <= WAIT;
              mem_addr <= fetch_addr;
            end
          end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
endmodule

// File: doc/fetch_align.md
FETCH_ALIGN -- requirements
Module: fetch_align

Interface
REQ-001 Reset is reset, asynchronous, active-high; clock is clk2; all state updates on posedge clk2.
REQ-002 clk2  in  1  system clock.
REQ-003 reset  in  1  async active-high reset.
REQ-004 mem_req  out  1  instruction-memory read request.
REQ-005 mem_addr  out  32  word-aligned read address, bits [1:0] always 0.
REQ-006 mem_ack  in  1  read data valid this cycle; completes the request.
REQ-007 mem_rdata  in  32  little-endian word: byte at mem_addr+0 in [7:0].
REQ-008 advance  in  4  bytes consumed by decode this cycle, legal 0..6; driven from decode num_of_ope.
REQ-009 jump  in  1  redirect pulse.
REQ-010 jump_target  in  32  new eip, any alignment.
REQ-011 ope  out  32  byte at eip in [31:24], eip+1 in [23:16], eip+2 in [15:8], eip+3 in [7:0]; feeds decode ope.
REQ-012 ope_valid  out  1  at least 6 bytes buffered.
REQ-013 eip  out  32  address of the byte in ope[31:24].
REQ-014 adv_err  out  1  sticky: advance >6, or advance nonzero while ope_valid=0.

Function
REQ-015 Byte buffer SHALL hold 12 bytes, with count 0..12 and the head byte at eip.
REQ-016 ope_valid SHALL be count>=6; ope SHALL be taken combinationally from buffer bytes 0..3. Bytes beyond count are don't-care.
REQ-017 Advance SHALL apply only when ope_valid=1 and advance<=6: eip+=advance and count-=advance.
- Illegal advance: eip and count are unchanged, and adv_err is set.
- advance=0 is a no-op.
REQ-018 FSM states:
- IDLE: no request outstanding.
- WAIT: request outstanding.
- DROP: outstanding request whose data is to be discarded.
REQ-019 IDLE->WAIT when the projected count (after this cycle's advance) <=8 and jump=0. mem_req is asserted in the following cycle and held with a stable mem_addr until mem_ack.
REQ-020 WAIT with mem_ack:
- Append 4-skip bytes, with skip=fetch_off (0..3).
- Clear skip.
- fetch_addr+=4.
- Go to IDLE, or stay in WAIT with the next address if the projected count after append is still <=8.
REQ-021 On the same cycle, mem_ack append and advance SHALL combine: count_next = count - advance + (4 - skip).
REQ-022 On jump:
- eip=jump_target, count=0, fetch_addr=jump_target&~3, skip=jump_target[1:0].
- Jump wins over advance and over a same-cycle mem_ack (that data is discarded).
REQ-023 A jump while in WAIT without mem_ack SHALL go to DROP. DROP keeps mem_req and mem_addr until mem_ack, discards the data, then issues the request for the new fetch_addr.
REQ-024 A jump while in DROP SHALL update the target and remain in DROP.
REQ-025 At most one request SHALL be outstanding. fetch_addr wraps modulo 2^32, and eip wraps modulo 2^32.
REQ-026 Buffer overflow SHALL be impossible because a request is issued only when at least 4 bytes are free after a worst-case advance of 0.

Reset
REQ-027 Reset values:
- eip=0, fetch_addr=0, skip=0, count=0.
- State IDLE, mem_req=0, ope_valid=0, adv_err=0.
- ope undefined-safe 0.
REQ-028 First request: mem_req rises on the first clk2 edge after reset deasserts, with mem_addr=0.
REQ-029 Reset mid-request SHALL drop mem_req immediately (async). A late mem_ack after reset is ignored in IDLE.

Structure
REQ-030 Shared package fetch_pkg SHALL hold:
- BUF_BYTES=12, MAX_OPE_LEN=6, FETCH_THRESH=8.
- The 2-bit state encoding IDLE=0, WAIT=1, DROP=2.
REQ-031 One sub-module, byte_queue, SHALL implement the 12-byte shift/append buffer (inputs: pop count, push bytes, push count, flush).
REQ-032 Top-level RTL holds the FSM, fetch_addr, eip and error logic.

Verification
REQ-033 Reset, then memory with zero-wait ack returning 0x04030201, 0x08070605. Requires:
- Requests at addresses 0 and 4.
- ope_valid=1 with ope=0x01020304 and eip=0.
REQ-034 Continuing from REQ-033, advance=1 for one cycle. Requires ope=0x02030405, eip=1, count=7, and a request issued at address 8.
REQ-035 jump target 0x102, memory word 0x100=0xDDCCBBAA, 0x104=0x44332211. Requires:
- Only bytes CC, DD are kept.
- ope=0xCCDD1122 once 6 bytes are buffered, eip=0x102.
REQ-036 jump asserted while WAIT with ack delayed 3 cycles. Requires:
- mem_addr is held until ack.
- The old data is discarded (DROP).
- The next request goes to the new target's word.
REQ-037 advance=7 while valid, and advance=2 while ope_valid=0. Requires adv_err=1 sticky, with eip and count unchanged.
REQ-038 Simultaneous mem_ack and advance=6 at count=8. Requires count=6 next cycle with the correct byte order.
